gcd_stein_unit: RTL and testbench

//  Parametrised highest-common-factor engine using binary (Stein) GCD: shifts and subtracts only, no divider.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_stein_unit_if.sv | 25 ++
 rtl/gcd_stein_step.sv | 54 +++++
 rtl/gcd_stein_unit.sv | 117 +++++++++++
 tb/tb_gcd_stein_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types for the binary GCD coprocessor
package gcd_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        FACTOR = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gcd_stein_unit_if.sv
// rtl/gcd_stein_unit_if.sv - operand/result handshake bundle for gcd_stein_unit
interface gcd_stein_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] hcf_out;
    logic [CNT_W-1:0] iter_out;
    logic             zero_err;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, hcf_out, iter_out, zero_err
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, hcf_out, iter_out, zero_err
    );
endinterface

// File: rtl/gcd_stein_step.sv
// rtl/gcd_stein_step.sv - one combinational Stein iteration (common-factor strip or reduce)
module gcd_stein_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K_W   = 4
) (
    input  state_t           state,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [K_W-1:0]   k_nxt,
    output state_t           state_nxt,
    output logic             done
);

    always_comb begin
        a_nxt     = a;
        b_nxt     = b;
        k_nxt     = k;
        state_nxt = state;
        done      = 1'b0;
        case (state)
            FACTOR: begin
                if (!a[0] && !b[0]) begin
                    a_nxt = a >> 1;
                    b_nxt = b >> 1;
                    k_nxt = k + 1'b1;
                end else begin
                    state_nxt = REDUCE;
                end
            end
            REDUCE: begin
                // Both odd before any compare; subtracting keeps the pair odd/even alternating.
                if (!a[0]) begin
                    a_nxt = a >> 1;
                end else if (!b[0]) begin
                    b_nxt = b >> 1;
                end else if (a == b) begin
                    done      = 1'b1;
                    state_nxt = DONE;
                end else if (a > b) begin
                    a_nxt = a - b;
                end else begin
                    b_nxt = b - a;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gcd_stein_unit.sv
// rtl/gcd_stein_unit.sv - multi-cycle binary GCD coprocessor with valid/ready handshakes
module gcd_stein_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           clear,
    gcd_stein_unit_if.slave io
);

    localparam int K_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d, step_state;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hcf_q, hcf_d;
    logic [WIDTH-1:0] step_a, step_b;
    logic [K_W-1:0]   k_q, k_d, step_k;
    logic [CNT_W-1:0] cnt_q, cnt_d, iter_q, iter_d, cnt_inc;
    logic             zerr_q, zerr_d;
    logic             step_done, accept, zero_op;

    gcd_stein_step #(.WIDTH(WIDTH), .K_W(K_W)) u_step (
        .state     (state_q),
        .a         (a_q),
        .b         (b_q),
        .k         (k_q),
        .a_nxt     (step_a),
        .b_nxt     (step_b),
        .k_nxt     (step_k),
        .state_nxt (step_state),
        .done      (step_done)
    );

    assign accept  = (state_q == IDLE) && io.in_valid;
    assign zero_op = (io.a_in == '0) || (io.b_in == '0);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            hcf_q   <= '0;
            iter_q  <= '0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            hcf_q   <= hcf_d;
            iter_q  <= iter_d;
            zerr_q  <= zerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           if (accept) state_d = zero_op ? DONE : FACTOR;
            FACTOR, REDUCE: state_d = step_state;
            DONE:           if (io.out_ready) state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        k_d    = k_q;
        cnt_d  = cnt_q;
        hcf_d  = hcf_q;
        iter_d = iter_q;
        zerr_d = zerr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = io.a_in;
                    b_d   = io.b_in;
                    k_d   = '0;
                    cnt_d = '0;
                    // A zero operand makes the other one the answer; no iterations needed.
                    if (zero_op) begin
                        hcf_d  = io.a_in | io.b_in;
                        zerr_d = (io.a_in == '0) && (io.b_in == '0);
                        iter_d = '0;
                    end
                end
            end
            FACTOR, REDUCE: begin
                a_d   = step_a;
                b_d   = step_b;
                k_d   = step_k;
                cnt_d = cnt_inc;
                if (step_done) begin
                    hcf_d  = a_q << k_q;
                    iter_d = cnt_inc;
                    zerr_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        io.in_ready  = (state_q == IDLE);
        io.out_valid = (state_q == DONE);
        io.hcf_out   = hcf_q;
        io.iter_out  = iter_q;
        io.zero_err  = zerr_q;
    end

endmodule

// File: tb/tb_gcd_stein_unit.sv
// tb/tb_gcd_stein_unit.sv - directed and table-driven bench for gcd_stein_unit
module tb_gcd_stein_unit;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    gcd_stein_unit_if #(.WIDTH(8),  .CNT_W(8)) if8  ();
    gcd_stein_unit_if #(.WIDTH(16), .CNT_W(8)) if16 ();
    gcd_stein_unit_if #(.WIDTH(8),  .CNT_W(3)) if3  ();

    gcd_stein_unit #(.WIDTH(8),  .CNT_W(8)) u8  (.clk(clk), .clear(clear), .io(if8));
    gcd_stein_unit #(.WIDTH(16), .CNT_W(8)) u16 (.clk(clk), .clear(clear), .io(if16));
    gcd_stein_unit #(.WIDTH(8),  .CNT_W(3)) u3  (.clk(clk), .clear(clear), .io(if3));

    int passed = 0;
    int total  = 0;

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hcf;
        int          iter;
        logic        zerr;
    } vec_t;

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic drive(int w, logic v, logic [15:0] a, logic [15:0] b, logic r);
        case (w)
            0: begin if8.in_valid = v;  if8.a_in = a[7:0];  if8.b_in = b[7:0];  if8.out_ready = r;  end
            1: begin if16.in_valid = v; if16.a_in = a;      if16.b_in = b;      if16.out_ready = r; end
            default: begin if3.in_valid = v; if3.a_in = a[7:0]; if3.b_in = b[7:0]; if3.out_ready = r; end
        endcase
    endtask

    function automatic logic get_ovld(int w);
        return (w == 0) ? if8.out_valid : (w == 1) ? if16.out_valid : if3.out_valid;
    endfunction
    function automatic logic get_irdy(int w);
        return (w == 0) ? if8.in_ready : (w == 1) ? if16.in_ready : if3.in_ready;
    endfunction
    function automatic logic [15:0] get_hcf(int w);
        return (w == 0) ? {8'd0, if8.hcf_out} : (w == 1) ? if16.hcf_out : {8'd0, if3.hcf_out};
    endfunction
    function automatic int get_iter(int w);
        return (w == 0) ? int'(if8.iter_out) : (w == 1) ? int'(if16.iter_out) : int'(if3.iter_out);
    endfunction
    function automatic logic get_zerr(int w);
        return (w == 0) ? if8.zero_err : (w == 1) ? if16.zero_err : if3.zero_err;
    endfunction

    function automatic logic [15:0] ref_gcd(logic [15:0] a, logic [15:0] b);
        logic [15:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // lat counts negedges from acceptance to the first sample showing out_valid.
    task automatic run(int w, logic [15:0] a, logic [15:0] b, output logic [15:0] hcf,
                       output int iter, output logic zerr, output int lat);
        int n = 0;
        while (!get_irdy(w) && n < 50) begin @(negedge clk); n++; end
        drive(w, 1'b1, a, b, 1'b0);
        @(negedge clk);
        drive(w, 1'b0, 16'd0, 16'd0, 1'b0);
        lat = 1;
        while (!get_ovld(w) && lat < 300) begin @(negedge clk); lat++; end
        check("result_timeout", lat < 300, 1);
        hcf  = get_hcf(w);
        iter = get_iter(w);
        zerr = get_zerr(w);
        drive(w, 1'b0, 16'd0, 16'd0, 1'b1);
        @(negedge clk);
        drive(w, 1'b0, 16'd0, 16'd0, 1'b0);
        check("release_valid_ready", {get_ovld(w), get_irdy(w)}, 2'b01);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [15:0] hcf, ra, rb;
        int          iter, lat, n;
        logic        zerr;

        vecs = '{
            '{0,   8,  12,   4,  7, 0},
            '{0,  17,   5,   1,  9, 0},
            '{0, 255, 255, 255,  2, 0},
            '{0,   0,   5,   5,  0, 0},
            '{0,   5,   0,   5,  0, 0},
            '{0,   0,   0,   0,  0, 1},
            '{0,  36,  24,  12,  7, 0},
            '{0, 128,  64,  64,  9, 0},
            '{0, 254, 127, 127,  3, 0},
            '{0,   1,   1,   1,  2, 0},
            '{1, 65535, 1,   1, 32, 0},
            '{1, 40000, 25000, 5000, -1, 0},
            '{2,  17,   5,   1,  7, 0},
            '{2, 128,  64,  64,  7, 0},
            '{2,   8,  12,   4,  7, 0},
            '{2, 255, 255, 255,  2, 0}
        };

        for (int w = 0; w < 3; w++) drive(w, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        clear = 1'b0;
        check("reset_in_ready",  if8.in_ready, 1);
        check("reset_out_valid", if8.out_valid, 0);
        check("reset_hcf",       if8.hcf_out, 0);
        check("reset_iter",      if8.iter_out, 0);
        check("reset_zero_err",  if8.zero_err, 0);

        foreach (vecs[i]) begin
            run(vecs[i].w, vecs[i].a, vecs[i].b, hcf, iter, zerr, lat);
            check($sformatf("vec%0d_hcf", i), hcf, vecs[i].hcf);
            check($sformatf("vec%0d_zero_err", i), zerr, vecs[i].zerr);
            if (vecs[i].iter >= 0) check($sformatf("vec%0d_iter", i), iter, vecs[i].iter);
            if (vecs[i].w != 2) check($sformatf("vec%0d_latency", i), lat, iter + 1);
        end

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = (i == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            run(1, ra, rb, hcf, iter, zerr, lat);
            check($sformatf("rnd%0d_hcf(%0d,%0d)", i, ra, rb), hcf, ref_gcd(ra, rb));
            check($sformatf("rnd%0d_zero_err", i), zerr, (ra == 0) && (rb == 0));
            check($sformatf("rnd%0d_latency", i), lat, iter + 1);
        end

        // Backpressure: result held, in_ready low, in_valid pulses ignored.
        drive(0, 1'b1, 16'd8, 16'd12, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
        n = 0;
        while (!if8.out_valid && n < 100) begin @(negedge clk); n++; end
        check("bp_reach_done", n < 100, 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, i[0], 16'd3, 16'd9, 1'b0);
            @(negedge clk);
            check($sformatf("bp%0d_hold", i),
                  {if8.out_valid, if8.in_ready, if8.hcf_out, if8.iter_out, if8.zero_err},
                  {1'b1, 1'b0, 8'd4, 8'd7, 1'b0});
        end
        // in_valid held through the consume edge must not be taken that same cycle.
        drive(0, 1'b1, 16'd3, 16'd9, 1'b1);
        @(negedge clk);
        check("no_bypass_idle", {if8.out_valid, if8.in_ready}, 2'b01);
        drive(0, 1'b1, 16'd3, 16'd9, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
        check("after_accept_busy", if8.in_ready, 0);
        n = 0;
        while (!if8.out_valid && n < 100) begin @(negedge clk); n++; end
        check("post_bp_hcf",  if8.hcf_out, 3);
        check("post_bp_iter", if8.iter_out, 4);
        drive(0, 1'b0, 16'd0, 16'd0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 16'd0, 16'd0, 1'b0);

        // clear in the middle of REDUCE discards the operation and zeroes outputs.
        drive(0, 1'b1, 16'd17, 16'd5, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (4) @(negedge clk);
        check("mid_op_busy", {if8.out_valid, if8.in_ready}, 2'b00);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_in_ready",  if8.in_ready, 1);
        check("clr_out_valid", if8.out_valid, 0);
        check("clr_hcf",       if8.hcf_out, 0);
        check("clr_iter",      if8.iter_out, 0);
        check("clr_zero_err",  if8.zero_err, 0);
        run(0, 16'd36, 16'd24, hcf, iter, zerr, lat);
        check("post_clr_hcf",  hcf, 12);
        check("post_clr_iter", iter, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
